// File: rtl/ct_pmp_napot_enc.sv
// -----------------------------------------------------------------------------
// ct_pmp_napot_enc
//
// Purpose:
//   Inverse of the PMP address comparator. Accepts a region request (page-
//   granular base PA[39:12] plus log2 size k, region = 4KB << k), validates it,
//   encodes the NAPOT pmpaddr value, writes it into the selected PMP entry over
//   a valid/ack port and then returns a one-cycle status pulse.
//
//   Optional feature macro: PMP_NAPOT_ENC_TOR_EN
//     When defined, a request with req_tor=1 programs a TOR region instead:
//     entry idx-1 gets the bottom (A=OFF) and entry idx gets the exclusive
//     top (A=TOR). When undefined, req_tor/req_top are ignored.
//
// Ports:
//   cpuclk, cpurst_b       clock, asynchronous active-low reset
//   req_vld/req_rdy        request handshake (ready only while idle)
//   req_idx                target PMP entry
//   req_base               region base page number
//   req_size               size exponent k
//   req_tor, req_top       TOR request and exclusive top page (optional)
//   pmp_entry_lock         per-entry L bits, sampled in the check cycle only
//   enc_wr_vld/pmp_wr_ack  write handshake to the PMP register file
//   enc_wr_idx/addr/amode  write payload, held stable until acknowledged
//   enc_rsp_vld            one-cycle completion pulse
//   enc_rsp_err            error flag, valid with enc_rsp_vld
// -----------------------------------------------------------------------------
module ct_pmp_napot_enc #(
    parameter int ADDR_WIDTH = 28,
    parameter int ENTRY_NUM  = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [IDX_W-1:0]      req_idx,
    input  logic [ADDR_WIDTH-1:0] req_base,
    input  logic [4:0]            req_size,
    input  logic                  req_tor,
    input  logic [ADDR_WIDTH-1:0] req_top,
    input  logic [ENTRY_NUM-1:0]  pmp_entry_lock,
    output logic                  enc_wr_vld,
    output logic [IDX_W-1:0]      enc_wr_idx,
    output logic [ADDR_WIDTH:0]   enc_wr_addr,
    output logic [1:0]            enc_wr_amode,
    input  logic                  pmp_wr_ack,
    output logic                  enc_rsp_vld,
    output logic                  enc_rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WR_LO,
        S_WR,
        S_RSP
    } state_e;

    localparam logic [1:0] AMODE_OFF   = 2'b00;
    localparam logic [1:0] AMODE_TOR   = 2'b01;
    localparam logic [1:0] AMODE_NAPOT = 2'b11;

    localparam logic [4:0]          MAX_K = 5'(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [4:0]              size_q, size_d;
    logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
    logic [ADDR_WIDTH:0]     wr_addr_q, wr_addr_d;
    logic [1:0]              wr_amode_q, wr_amode_d;
    logic                    rsp_err_q, rsp_err_d;

    // NAPOT datapath: ones_k = (1<<k)-1. Out-of-range k is rejected as an
    // error, so its wrapped shift value never reaches the write port.
    logic [ADDR_WIDTH:0]     ones_k;
    logic                    napot_err;
    logic [ADDR_WIDTH:0]     napot_addr;

    always_comb begin
        ones_k     = (ONE << size_q) - ONE;
        napot_err  = (size_q > MAX_K)
                   || (|(base_q & ones_k[ADDR_WIDTH-1:0]))
                   || pmp_entry_lock[idx_q];
        // Clear bits [k:0] of {base,0}, then fill bits [k-1:0] with ones.
        // Bit k ends up zero, which is the NAPOT size marker.
        napot_addr = ({base_q, 1'b0} & ~{ones_k[ADDR_WIDTH-1:0], 1'b1}) | ones_k;
    end

`ifdef PMP_NAPOT_ENC_TOR_EN
    logic                    tor_q, tor_d;
    logic [ADDR_WIDTH-1:0]   top_q, top_d;
    logic                    tor_err;
    logic [IDX_W-1:0]        idx_lo;

    always_comb begin
        idx_lo  = idx_q - IDX_W'(1);
        // Entry 0 has an implicit bottom of address 0, so it cannot take a
        // non-zero base; otherwise the bottom lives in entry idx-1, which
        // must be writable too.
        tor_err = (top_q <= base_q)
                || pmp_entry_lock[idx_q]
                || ((idx_q != '0) && pmp_entry_lock[idx_lo])
                || ((idx_q == '0) && (base_q != '0));
    end
`else
    logic unused_tor;
    assign unused_tor = ^{req_tor, req_top};
`endif

    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        size_d     = size_q;
        wr_idx_d   = wr_idx_q;
        wr_addr_d  = wr_addr_q;
        wr_amode_d = wr_amode_q;
        rsp_err_d  = rsp_err_q;
`ifdef PMP_NAPOT_ENC_TOR_EN
        tor_d      = tor_q;
        top_d      = top_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_vld) begin
                    idx_d     = req_idx;
                    base_d    = req_base;
                    size_d    = req_size;
                    rsp_err_d = 1'b0;
`ifdef PMP_NAPOT_ENC_TOR_EN
                    tor_d     = req_tor;
                    top_d     = req_top;
`endif
                    state_d   = S_CHECK;
                end
            end

            S_CHECK: begin
`ifdef PMP_NAPOT_ENC_TOR_EN
                if (tor_q) begin
                    if (tor_err) begin
                        rsp_err_d = 1'b1;
                        state_d   = S_RSP;
                    end else if (idx_q != '0) begin
                        wr_idx_d   = idx_lo;
                        wr_addr_d  = {base_q, 1'b0};
                        wr_amode_d = AMODE_OFF;
                        state_d    = S_WR_LO;
                    end else begin
                        wr_idx_d   = idx_q;
                        wr_addr_d  = {top_q, 1'b0};
                        wr_amode_d = AMODE_TOR;
                        state_d    = S_WR;
                    end
                end else begin
                    if (napot_err) begin
                        rsp_err_d = 1'b1;
                        state_d   = S_RSP;
                    end else begin
                        wr_idx_d   = idx_q;
                        wr_addr_d  = napot_addr;
                        wr_amode_d = AMODE_NAPOT;
                        state_d    = S_WR;
                    end
                end
`else
                if (napot_err) begin
                    rsp_err_d = 1'b1;
                    state_d   = S_RSP;
                end else begin
                    wr_idx_d   = idx_q;
                    wr_addr_d  = napot_addr;
                    wr_amode_d = AMODE_NAPOT;
                    state_d    = S_WR;
                end
`endif
            end

            S_WR_LO: begin
`ifdef PMP_NAPOT_ENC_TOR_EN
                if (pmp_wr_ack) begin
                    wr_idx_d   = idx_q;
                    wr_addr_d  = {top_q, 1'b0};
                    wr_amode_d = AMODE_TOR;
                    state_d    = S_WR;
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_WR: begin
                if (pmp_wr_ack) begin
                    state_d = S_RSP;
                end
            end

            S_RSP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            base_q     <= '0;
            size_q     <= '0;
            wr_idx_q   <= '0;
            wr_addr_q  <= '0;
            wr_amode_q <= AMODE_OFF;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            size_q     <= size_d;
            wr_idx_q   <= wr_idx_d;
            wr_addr_q  <= wr_addr_d;
            wr_amode_q <= wr_amode_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef PMP_NAPOT_ENC_TOR_EN
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            tor_q <= 1'b0;
            top_q <= '0;
        end else begin
            tor_q <= tor_d;
            top_q <= top_d;
        end
    end
`endif

    // Handshake outputs decode directly from the state, so an async reset
    // drops enc_wr_vld in the same instant.
    assign req_rdy      = (state_q == S_IDLE);
    assign enc_wr_vld   = (state_q == S_WR) || (state_q == S_WR_LO);
    assign enc_rsp_vld  = (state_q == S_RSP);
    assign enc_rsp_err  = rsp_err_q;
    assign enc_wr_idx   = wr_idx_q;
    assign enc_wr_addr  = wr_addr_q;
    assign enc_wr_amode = wr_amode_q;

endmodule
